// File: rtl/led_matrix_scan_driver.sv
// Column-multiplexed LED matrix driver: serial pixel chain, stage and display buffers, column scan.
// Optional LED_BLANK_EN macro blanks the first BLANK cycles of every column.
module led_matrix_scan_driver #(
  parameter int ROWS  = 8,
  parameter int COLS  = 8,
  parameter int DWELL = 4,
  parameter int BLANK = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ena,
  input  logic            sdata,
  input  logic            shift_en,
  input  logic            latch,
  output logic [ROWS-1:0] row_out,
  output logic [COLS-1:0] col_sel,
  output logic            frame_start,
  output logic            pending
);

  localparam int N  = ROWS * COLS;
  localparam int DW = $clog2(DWELL);
  localparam int CW = $clog2(COLS);
`ifdef LED_BLANK_EN
  localparam bit BLANK_ON = 1'b1;
`else
  localparam bit BLANK_ON = 1'b0;
`endif

  logic [N-1:0]    chain;
  logic [N-1:0]    stage;
  logic [N-1:0]    display;
  logic [N-1:0]    display_nxt;
  logic [DW-1:0]   dwell_cnt;
  logic [CW-1:0]   col_idx;
  logic            latch_q;
  logic            latch_edge;
  logic            dwell_end;
  logic            col_end;
  logic            wrap;
  logic            blank;
  logic            drive;
  logic [COLS-1:0] col_onehot;
  logic [ROWS-1:0] row_sel;

  assign latch_edge = latch & ~latch_q;
  assign dwell_end  = (dwell_cnt == DW'(DWELL - 1));
  assign col_end    = (col_idx == CW'(COLS - 1));
  assign wrap       = ena & dwell_end & col_end;
  assign blank      = BLANK_ON & (dwell_cnt < DW'(BLANK));
  assign drive      = ena & ~blank;

  // The frame_start cycle is the swap window: a latch edge landing there bypasses the stage.
  always_comb begin
    display_nxt = display;
    if (frame_start) begin
      if (latch_edge)
        display_nxt = chain;
      else if (pending)
        display_nxt = stage;
    end
  end

  // Column slice taken from display_nxt so a swap is visible on the first column-0 cycle.
  always_comb begin
    col_onehot = '0;
    row_sel    = '0;
    for (int c = 0; c < COLS; c++) begin
      if (col_idx == CW'(c)) begin
        col_onehot[c] = 1'b1;
        row_sel       = display_nxt[c*ROWS +: ROWS];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain       <= '0;
      stage       <= '0;
      display     <= '0;
      dwell_cnt   <= '0;
      col_idx     <= '0;
      latch_q     <= 1'b0;
      pending     <= 1'b0;
      frame_start <= 1'b0;
      col_sel     <= '0;
      row_out     <= '0;
    end else begin
      latch_q <= latch;
      if (shift_en)
        chain <= {chain[N-2:0], sdata};
      if (latch_edge)
        stage <= chain;
      display <= display_nxt;
      if (frame_start)
        pending <= 1'b0;
      else if (latch_edge)
        pending <= 1'b1;
      frame_start <= wrap;
      if (ena) begin
        if (dwell_end) begin
          dwell_cnt <= '0;
          col_idx   <= col_end ? '0 : col_idx + 1'b1;
        end else begin
          dwell_cnt <= dwell_cnt + 1'b1;
        end
      end
      col_sel <= drive ? col_onehot : '0;
      row_out <= drive ? row_sel : '0;
    end
  end

endmodule

// File: tb/tb_led_matrix_scan_driver.sv
// Directed scenarios plus random traffic for led_matrix_scan_driver, checked against a
// frame-position reference model (LED_BLANK_EN honoured if defined).
module tb_led_matrix_scan_driver;

  localparam int ROWS  = 8;
  localparam int COLS  = 8;
  localparam int DWELL = 4;
  localparam int BLANK = 1;
  localparam int N     = ROWS * COLS;
  localparam int PER   = COLS * DWELL;
`ifdef LED_BLANK_EN
  localparam bit BLANK_ON = 1'b1;
`else
  localparam bit BLANK_ON = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            ena = 1'b0;
  logic            sdata = 1'b0;
  logic            shift_en = 1'b0;
  logic            latch = 1'b0;
  logic [ROWS-1:0] row_out;
  logic [COLS-1:0] col_sel;
  logic            frame_start;
  logic            pending;

  int checks = 0;
  int errors = 0;

  // Reference model: frame position counts 0..PER-1 while enabled
  logic [N-1:0]    m_chain, m_stage, m_disp;
  logic            m_pending, m_prev_latch, m_fs;
  logic [ROWS-1:0] m_row;
  logic [COLS-1:0] m_col;
  int              m_pos;

  led_matrix_scan_driver #(.ROWS(ROWS), .COLS(COLS), .DWELL(DWELL), .BLANK(BLANK)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .sdata(sdata), .shift_en(shift_en), .latch(latch),
    .row_out(row_out), .col_sel(col_sel), .frame_start(frame_start), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_chain = '0; m_stage = '0; m_disp = '0;
    m_pending = 1'b0; m_prev_latch = 1'b0; m_fs = 1'b0;
    m_row = '0; m_col = '0; m_pos = 0;
  endtask

  task automatic model_cycle(input logic e, input logic sd, input logic se, input logic la);
    logic le;
    int c, d;
    le = la && !m_prev_latch;
    if (m_fs) begin
      if (le) m_disp = m_chain;
      else if (m_pending) m_disp = m_stage;
      m_pending = 1'b0;
    end else if (le) begin
      m_pending = 1'b1;
    end
    if (le) m_stage = m_chain;
    c = m_pos / DWELL;
    d = m_pos % DWELL;
    m_col = '0;
    m_row = '0;
    if (e && !(BLANK_ON && d < BLANK)) begin
      m_col[c] = 1'b1;
      m_row = m_disp[c*ROWS +: ROWS];
    end
    m_fs = e && (m_pos == PER - 1);
    if (e) m_pos = (m_pos + 1) % PER;
    if (se) m_chain = {m_chain[N-2:0], sd};
    m_prev_latch = la;
  endtask

  // Inputs change at a falling edge; outputs are compared at the next falling edge
  task automatic step(input logic e, input logic sd, input logic se, input logic la);
    ena = e; sdata = sd; shift_en = se; latch = la;
    model_cycle(e, sd, se, la);
    @(negedge clk);
    chk("col_sel", N'(col_sel), N'(m_col));
    chk("row_out", N'(row_out), N'(m_row));
    chk("frame_start", N'(frame_start), N'(m_fs));
    chk("pending", N'(pending), N'(m_pending));
  endtask

  task automatic load(input logic [N-1:0] p, input logic e);
    for (int i = N - 1; i >= 0; i--) step(e, p[i], 1'b1, 1'b0);
  endtask

  task automatic wait_fs();
    for (int i = 0; i < 2 * PER && frame_start !== 1'b1; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("frame_start_seen", N'(frame_start), N'(1'b1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [N-1:0] pa, pb, pc, pd;
    logic [ROWS-1:0] exp_col6;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_col_sel", N'(col_sel), '0);
    chk("rst_row_out", N'(row_out), '0);
    chk("rst_frame_start", N'(frame_start), '0);
    chk("rst_pending", N'(pending), '0);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("release_col0", N'(col_sel), N'(BLANK_ON ? 8'h00 : 8'h01));

    // Column pattern: bit k set when k%8==3 -> 0x08 on every column
    for (int k = 0; k < N; k++) pa[k] = (k % 8 == 3);
    load(pa, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("pend_set", N'(pending), N'(1'b1));
    step(1'b0, 1'b0, 1'b0, 1'b0);
    wait_fs();
    chk("pend_until_fs", N'(pending), N'(1'b1));
    for (int i = 0; i < PER + 2; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      if (col_sel != '0) chk("row_0x08", N'(row_out), N'(8'h08));
    end

    // Two latches before one boundary: the later one wins
    pa = {$urandom, $urandom};
    pb = ~pa;
    load(pa, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    load(pb, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    wait_fs();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("last_wins_row", N'(row_out), N'(BLANK_ON ? 8'h00 : pb[ROWS-1:0]));
    for (int i = 0; i < PER; i++) step(1'b1, 1'b0, 1'b0, 1'b0);

    // Latch edge on the frame_start cycle loads the display directly
    pc = {$urandom, $urandom};
    load(pc, 1'b0);
    wait_fs();
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("direct_pending", N'(pending), N'(1'b0));
    chk("direct_col", N'(col_sel), N'(BLANK_ON ? 8'h00 : 8'h01));
    chk("direct_row", N'(row_out), N'(BLANK_ON ? 8'h00 : pc[ROWS-1:0]));
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("direct_row2", N'(row_out), N'(pc[ROWS-1:0]));

    // Pause in column 5 and resume from the frozen dwell count
    for (int i = 0; i < PER + 1 && m_pos != 5 * DWELL + 1; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      chk("pause_col", N'(col_sel), '0);
      chk("pause_row", N'(row_out), '0);
    end
    for (int i = 0; i < DWELL - 1; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      chk("resume_col5", N'(col_sel), N'(8'h20));
    end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    exp_col6 = BLANK_ON ? 8'h00 : 8'h40;
    chk("after_col5", N'(col_sel), N'(exp_col6));

    // Reset mid-column with a frame pending
    pd = {$urandom, $urandom} | 64'h1;
    load(pd, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("pend_before_rst", N'(pending), N'(1'b1));
    #2 rst_n = 1'b0;
    #1;
    chk("async_col", N'(col_sel), '0);
    chk("async_row", N'(row_out), '0);
    chk("async_fs", N'(frame_start), '0);
    chk("async_pend", N'(pending), '0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("rst2_col", N'(col_sel), N'(BLANK_ON ? 8'h00 : 8'h01));
    chk("rst2_row", N'(row_out), '0);
    chk("rst2_pend", N'(pending), '0);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic e, sd, se, la;
      e  = ($urandom_range(0, 7) != 0);
      sd = 1'($urandom);
      se = ($urandom_range(0, 3) != 0);
      la = ($urandom_range(0, 15) == 0) ? ~latch : latch;
      step(e, sd, se, la);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
